event_trace_player: RTL

Synthesisable, parametrised stimulus sequencer that replays a preloaded trace of timed input events into a monitor `topEntity`. It drives the `input_k` / `new_input_k` pairs exactly as hand-written benches do: one-cycle valid pulses with data returning to zero, spaced by per-event cycle deltas. It sits between a trace loader (host, ROM or bench) and the monitor's input ports. It replaces fixed-delay stimulus with a FIFO-fed, multi-channel, cycle-exact player.

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_fifo.sv | 70 +++++++
 rtl/event_trace_player.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the event trace player.
package trace_pkg;

   // Width of the fired-event counter.
   localparam int unsigned EvCountW = 16;

   // Default channel geometry; the player rebuilds the entry at its own widths.
   localparam int unsigned DefNumInputs = 1;
   localparam int unsigned DefDataW     = 64;
   localparam int unsigned DefDeltaW    = 32;

   // One trace entry: wait, channel mask, channel values, end-of-trace marker.
   typedef struct packed {
      logic [DefDeltaW-1:0]             delta;
      logic [DefNumInputs-1:0]          mask;
      logic [DefNumInputs*DefDataW-1:0] data;
      logic                             last;
   } trace_entry_t;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous trace FIFO with count-based full/empty and no write-to-read bypass.
module trace_fifo #(
   parameter int unsigned Depth = 16,
   parameter type         entry_t = logic
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   flush_i,
   input  logic   push_i,
   input  logic   pop_i,
   input  entry_t wdata_i,
   output entry_t rdata_o,
   output logic   empty_o,
   output logic   full_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = PtrW + 1;

   entry_t          mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign rdata_o = mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally since Depth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset since occupancy guards every read.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/event_trace_player.sv
// Replays a preloaded trace of timed events as one-cycle valid pulses on monitor inputs.
module event_trace_player
   import trace_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = 1,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned DELTA_W    = 32,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         ld_valid,
   output logic                         ld_ready,
   input  logic [DELTA_W-1:0]           ld_delta,
   input  logic [NUM_INPUTS-1:0]        ld_mask,
   input  logic [NUM_INPUTS*DATA_W-1:0] ld_data,
   input  logic                         ld_last,
   input  logic                         start,
   input  logic                         stop,
   output logic [NUM_INPUTS*DATA_W-1:0] input_bus,
   output logic [NUM_INPUTS-1:0]        new_input,
   output logic                         busy,
   output logic                         done,
   output logic                         underrun,
   output logic [EvCountW-1:0]          ev_count
);

   typedef struct packed {
      logic [DELTA_W-1:0]           delta;
      logic [NUM_INPUTS-1:0]        mask;
      logic [NUM_INPUTS*DATA_W-1:0] data;
      logic                         last;
   } entry_t;

   state_e                       state_q, state_d;
   logic [DELTA_W-1:0]           elapsed_q, elapsed_d;
   logic [EvCountW-1:0]          ev_count_q, ev_count_d;
   logic                         underrun_q, underrun_d;
   logic                         done_q, done_d;
   logic [NUM_INPUTS*DATA_W-1:0] bus_q, bus_d;
   logic [NUM_INPUTS-1:0]        new_q, new_d;

   entry_t           wr_entry, head;
   logic             fifo_empty, fifo_full;
   logic             push, pop, fire;
   logic [DELTA_W:0] elapsed_inc, delta_eff;

   assign wr_entry = '{delta: ld_delta, mask: ld_mask, data: ld_data, last: ld_last};
   assign push     = en && ld_valid && !fifo_full;
   assign ld_ready = !fifo_full;

   trace_fifo #(
      .Depth   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .flush_i (en && stop),
      .push_i  (push),
      .pop_i   (en && pop),
      .wdata_i (wr_entry),
      .rdata_o (head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // One extra bit keeps elapsed+1 exact at saturation; zero delta behaves as one.
   assign elapsed_inc = {1'b0, elapsed_q} + (DELTA_W+1)'(1);
   assign delta_eff   = (head.delta == '0) ? (DELTA_W+1)'(1) : {1'b0, head.delta};
   assign fire        = (state_q == StRun) && !fifo_empty && (elapsed_inc >= delta_eff);

   // Playback FSM, wait counter and next pulse contents.
   always_comb begin
      state_d    = state_q;
      elapsed_d  = elapsed_q;
      ev_count_d = ev_count_q;
      underrun_d = underrun_q;
      done_d     = done_q;
      bus_d      = '0;
      new_d      = '0;
      pop        = 1'b0;
      if (stop) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_d    = StRun;
                  elapsed_d  = '0;
                  ev_count_d = '0;
                  underrun_d = 1'b0;
                  done_d     = 1'b0;
               end
            end
            StRun: begin
               if (fire) begin
                  pop        = 1'b1;
                  new_d      = head.mask;
                  elapsed_d  = '0;
                  ev_count_d = ev_count_q + EvCountW'(1);
                  if (elapsed_inc > delta_eff) underrun_d = 1'b1;
                  for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
                     if (head.mask[k]) bus_d[k*DATA_W +: DATA_W] = head.data[k*DATA_W +: DATA_W];
                  end
                  if (head.last) begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
               end else if (!(&elapsed_q)) begin
                  elapsed_d = elapsed_inc[DELTA_W-1:0];
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and output registers; a low enable freezes everything, stretching live pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         elapsed_q  <= '0;
         ev_count_q <= '0;
         underrun_q <= 1'b0;
         done_q     <= 1'b0;
         bus_q      <= '0;
         new_q      <= '0;
      end else if (en) begin
         state_q    <= state_d;
         elapsed_q  <= elapsed_d;
         ev_count_q <= ev_count_d;
         underrun_q <= underrun_d;
         done_q     <= done_d;
         bus_q      <= bus_d;
         new_q      <= new_d;
      end
   end

   assign input_bus = bus_q;
   assign new_input = new_q;
   assign busy      = (state_q == StRun);
   assign done      = done_q;
   assign underrun  = underrun_q;
   assign ev_count  = ev_count_q;

endmodule
